// File: rtl/aes_pkg.sv
// Shared AES constants and combinational helpers: mode codes, Nk/Nr lookup,
// S-box, Rcon, xtime and MixColumns.
// No state; every function is purely combinational.
// Ports: none (package).
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    // S-box table, entry 0x00 in the top byte, entry 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    // Index of the final schedule word, 4*(Nr+1)-1.
    function automatic logic [5:0] last_word_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 6'd51;
            MODE_256: return 6'd59;
            default:  return 6'd43;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2040 - {x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon[i/Nk] with i/Nk starting at 1, so index 0 yields 0x01.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_iter.sv
// Iterative AES key schedule: one 32-bit word per step into a 60x32 round-key file.
// Latency: load writes w[0..Nk-1]; each step writes the next word; last flags the final word.
// Backpressure: none; the controlling FSM decides when to load and step.
// Ports: clk, rst, load/key/mode (start schedule), step, last, rk_idx -> rk (128-bit round key).
module aes_key_expand_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [255:0] key,
    input  logic [1:0]   mode,
    input  logic         step,
    output logic         last,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk
);

    logic [31:0] kf [60];
    logic [5:0]  wcnt;      // index of the word the next step writes
    logic [3:0]  kcnt;      // wcnt mod Nk, kept incrementally to avoid a divider
    logic [3:0]  rci;       // Rcon index
    logic [3:0]  nk_q;
    logic [5:0]  wlast_q;

    logic [31:0] prev, temp, new_w;
    logic [5:0]  base;

    always_comb begin
        prev = kf[wcnt - 6'd1];
        temp = prev;
        if (kcnt == 4'd0) begin
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(rci), 24'h000000};
        end else if (nk_q == 4'd8 && kcnt == 4'd4) begin
            temp = sub_word(prev);
        end
        new_w = kf[wcnt - {2'b00, nk_q}] ^ temp;
    end

    assign last = (wcnt == wlast_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt    <= '0;
            kcnt    <= '0;
            rci     <= '0;
            nk_q    <= 4'd4;
            wlast_q <= 6'd43;
        end else if (load) begin
            wcnt    <= {2'b00, nk_of(mode)};
            kcnt    <= '0;
            rci     <= '0;
            nk_q    <= nk_of(mode);
            wlast_q <= last_word_of(mode);
        end else if (step) begin
            wcnt <= wcnt + 6'd1;
            kcnt <= (kcnt == nk_q - 4'd1) ? 4'd0 : kcnt + 4'd1;
            if (kcnt == 4'd0) begin
                rci <= rci + 4'd1;
            end
        end
    end

    // Key storage carries no reset; it is always rewritten before use.
    // Loading all eight words is harmless for short keys: the extra slots
    // are overwritten by the schedule before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 8; k++) begin
                kf[k] <= key[255-32*k -: 32];
            end
        end else if (step) begin
            kf[wcnt] <= new_w;
        end
    end

    assign base = {rk_idx, 2'b00};
    assign rk   = {kf[base], kf[base + 6'd1], kf[base + 6'd2], kf[base + 6'd3]};

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor: on-the-fly key expansion, then one round per cycle.
// Latency: E+Nr+2 cycles (52/60/68); illegal mode 1 cycle; key reuse Nr+2 (AES_KEY_REUSE_EN).
// Backpressure: one block in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst; request in_valid/in_ready/in_mode/in_state/in_key/in_id[/in_key_keep];
//        result out_valid/out_ready/out_data/out_id/out_err.
// Optional: `define AES_KEY_REUSE_EN adds in_key_keep to skip re-expanding an unchanged key.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter bit ALLOW_192 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [127:0]    in_state,
    input  logic [255:0]    in_key,
    input  logic [ID_W-1:0] in_id,
`ifdef AES_KEY_REUSE_EN
    input  logic            in_key_keep,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic [ID_W-1:0] out_id,
    output logic            out_err
);

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

    state_t         st, nxt;
    logic [1:0]     mode_q;
    logic [127:0]   blk;
    logic [3:0]     rnd;
    logic           accept, illegal, reuse, last_rnd;
    logic           exp_load, exp_step, exp_last;
    logic [127:0]   rk, sr, mixed;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        end
        return r;
    endfunction

    // Column-major byte k = row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    assign in_ready  = (st == IDLE) && !rst;
    assign out_valid = (st == DONE);
    assign accept    = in_valid && in_ready;
    assign illegal   = (in_mode == MODE_ILL) || (in_mode == MODE_192 && !ALLOW_192);
    assign last_rnd  = (rnd == nr_of(mode_q));
    assign sr        = shift_rows(sub_bytes(blk));
    assign mixed     = mix_columns(sr);

`ifdef AES_KEY_REUSE_EN
    // key_vld: the key file holds a complete schedule for key_mode.
    logic       key_vld;
    logic [1:0] key_mode;

    assign reuse = in_key_keep && key_vld && (key_mode == in_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_vld  <= 1'b0;
            key_mode <= MODE_128;
        end else if (exp_load) begin
            key_vld  <= 1'b0;
            key_mode <= in_mode;
        end else if (exp_step && exp_last) begin
            key_vld  <= 1'b1;
        end
    end
`else
    assign reuse = 1'b0;
`endif

    aes_key_expand_iter u_kexp (
        .clk    (clk),
        .rst    (rst),
        .load   (exp_load),
        .key    (in_key),
        .mode   (in_mode),
        .step   (exp_step),
        .last   (exp_last),
        .rk_idx (rnd),
        .rk     (rk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt      = st;
        exp_load = 1'b0;
        exp_step = 1'b0;
        case (st)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        nxt = DONE;
                    end else if (reuse) begin
                        nxt = ROUND;
                    end else begin
                        nxt      = EXPAND;
                        exp_load = 1'b1;
                    end
                end
            end
            EXPAND: begin
                exp_step = 1'b1;
                if (exp_last) begin
                    nxt = ROUND;
                end
            end
            ROUND: begin
                if (last_rnd) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_128;
            blk      <= '0;
            rnd      <= '0;
            out_data <= '0;
            out_id   <= '0;
            out_err  <= 1'b0;
        end else if (st == IDLE) begin
            if (accept) begin
                mode_q  <= in_mode;
                blk     <= in_state;
                rnd     <= '0;
                out_id  <= in_id;
                out_err <= illegal;
                if (illegal) begin
                    out_data <= '0;
                end
            end
        end else if (st == ROUND) begin
            rnd <= rnd + 4'd1;
            if (rnd == 4'd0) begin
                blk <= blk ^ rk;
            end else if (!last_rnd) begin
                blk <= mixed ^ rk;
            end else begin
                out_data <= sr ^ rk;
                rnd      <= '0;
            end
        end
    end

endmodule
